// File: rtl/sd_pkg.sv
// Shared types and width helpers for the windowed standard-deviation unit.
package sd_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_VAR   = 2'd1,
        ST_ROOT  = 2'd2,
        ST_OUT   = 2'd3
    } sd_state_e;

    function automatic int sum_w(input int width, input int log_n);
        return width + log_n;
    endfunction

    function automatic int sq_w(input int width, input int log_n);
        return 2 * width + log_n;
    endfunction

    function automatic int root_w(input int width, input int fbits);
        return width + fbits;
    endfunction

endpackage

// File: rtl/sd_window_sqrt_iter.sv
// Restoring digit-by-digit square root, one result bit per cycle, MSB first.
// root/rem present the result of the step in progress; they are final while done=1.
module sqrt_iter #(
    parameter int RAD_W  = 16,
    parameter int ROOT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [RAD_W-1:0]  rad,
    output logic [ROOT_W-1:0] root,
    output logic [ROOT_W:0]   rem
);

    localparam int CNT_W = $clog2(ROOT_W + 1);

    logic [RAD_W-1:0]  rad_q;
    logic [ROOT_W-1:0] root_q;
    logic [ROOT_W:0]   rem_q;
    logic [CNT_W-1:0]  left_q;
    logic              busy_q;

    logic [ROOT_W+2:0] acc;
    logic [ROOT_W+2:0] trial;
    logic [ROOT_W-1:0] root_step;
    logic [ROOT_W:0]   rem_step;

    always_comb begin
        acc   = {rem_q, rad_q[RAD_W-1 -: 2]};
        trial = {1'b0, root_q, 2'b01};
        if (acc >= trial) begin
            rem_step  = (ROOT_W+1)'(acc - trial);
            root_step = ROOT_W'({root_q, 1'b1});
        end else begin
            rem_step  = (ROOT_W+1)'(acc);
            root_step = ROOT_W'({root_q, 1'b0});
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (left_q == CNT_W'(1));
    assign root = root_step;
    assign rem  = rem_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            rad_q  <= '0;
            root_q <= '0;
            rem_q  <= '0;
            left_q <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rad_q  <= rad;
            root_q <= '0;
            rem_q  <= '0;
            left_q <= CNT_W'(ROOT_W);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rad_q  <= rad_q << 2;
            root_q <= root_step;
            rem_q  <= rem_step;
            left_q <= left_q - CNT_W'(1);
            if (left_q == CNT_W'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sd_window.sv
// Windowed mean / standard deviation over 2^LOG_N samples with valid/ready output.
// Define SD_ROUND_EN to round sd_out to nearest instead of truncating.
module sd_window
    import sd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FBITS = 0,
    parameter int LOG_N = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       mean_out,
    output logic [WIDTH+FBITS-1:0] sd_out,
    output sd_state_e              dbg_state_o
);

    localparam int SUM_W  = sum_w(WIDTH, LOG_N);
    localparam int SQ_W   = sq_w(WIDTH, LOG_N);
    localparam int ROOT_W = root_w(WIDTH, FBITS);
    localparam int RAD_W  = 2 * ROOT_W;
    localparam int VAR_W  = 2 * WIDTH;
    localparam int CNT_W  = (LOG_N > 0) ? LOG_N : 1;
    localparam int N      = 1 << LOG_N;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    sd_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [SQ_W-1:0]   sumsq_q, sumsq_d;
    logic [WIDTH-1:0]  mean_q, mean_d;
    logic [ROOT_W-1:0] sd_q, sd_d;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [WIDTH-1:0]  mean_v;
    logic [VAR_W-1:0]  msq_v;
    logic [VAR_W-1:0]  mean_sq_v;
    logic [VAR_W-1:0]  var_v;
    logic [RAD_W-1:0]  rad_v;
    logic [ROOT_W-1:0] sd_next;

    logic              sq_start;
    logic              sq_busy;
    logic              sq_done;
    logic [ROOT_W-1:0] sq_root;
    logic [ROOT_W:0]   sq_rem;

    sqrt_iter #(
        .RAD_W (RAD_W),
        .ROOT_W(ROOT_W)
    ) u_sqrt (
        .clk  (clk),
        .reset(reset),
        .start(sq_start),
        .busy (sq_busy),
        .done (sq_done),
        .rad  (rad_v),
        .root (sq_root),
        .rem  (sq_rem)
    );

    // floor(sumsq/N) >= floor(sum/N)^2 always holds, so the subtraction cannot wrap.
    always_comb begin
        mean_v    = WIDTH'(sum_q >> LOG_N);
        msq_v     = VAR_W'(sumsq_q >> LOG_N);
        mean_sq_v = VAR_W'(mean_v) * VAR_W'(mean_v);
        var_v     = msq_v - mean_sq_v;
        rad_v     = RAD_W'(var_v) << (2 * FBITS);
    end

`ifdef SD_ROUND_EN
    always_comb begin
        sd_next = sq_root;
        if (({1'b0, sq_root} < sq_rem) && !(&sq_root)) begin
            sd_next = sq_root + ROOT_W'(1);
        end
    end
`else
    logic unused_rem;
    assign unused_rem = ^sq_rem;
    assign sd_next    = sq_root;
`endif

    // Input side: a sample moves on a clock edge where in_valid && in_ready; output side:
    // a result moves where out_valid && out_ready. Both ready/valid outputs are registered.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        sumsq_d  = sumsq_q;
        mean_d   = mean_q;
        sd_d     = sd_q;
        sq_start = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (in_valid && in_ready_q) begin
                    sum_d   = sum_q + SUM_W'(in_data);
                    sumsq_d = sumsq_q + SQ_W'(in_data) * SQ_W'(in_data);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_VAR;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_VAR: begin
                mean_d   = mean_v;
                sq_start = !sq_busy;
                sum_d    = '0;
                sumsq_d  = '0;
                state_d  = ST_ROOT;
            end
            ST_ROOT: begin
                if (sq_done) begin
                    sd_d    = sd_next;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ACCUM;
            cnt_q       <= '0;
            sum_q       <= '0;
            sumsq_q     <= '0;
            mean_q      <= '0;
            sd_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            sumsq_q     <= sumsq_d;
            mean_q      <= mean_d;
            sd_q        <= sd_d;
            in_ready_q  <= (state_d == ST_ACCUM);
            out_valid_q <= (state_d == ST_OUT);
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign mean_out    = mean_q;
    assign sd_out      = sd_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sd_window.sv
// Bench for sd_window: three instances (LOG_N=2/FBITS=0, LOG_N=2/FBITS=4, LOG_N=0/FBITS=0).
module tb_sd_window;
    import sd_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] in_valid = '0;
    logic [2:0] out_ready = '0;
    logic [7:0] in_data [3];
    wire  [2:0] in_ready;
    wire  [2:0] out_valid;
    wire  [7:0] mean_a, mean_b, mean_c;
    wire  [7:0] sd_a, sd_c;
    wire  [11:0] sd_b;
    sd_state_e  dbg_a, dbg_b, dbg_c;

    int errors = 0;
    int checks = 0;
    int smp_q[$];
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    sd_window #(.WIDTH(8), .FBITS(0), .LOG_N(2)) u_a (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .mean_out(mean_a), .sd_out(sd_a), .dbg_state_o(dbg_a));

    sd_window #(.WIDTH(8), .FBITS(4), .LOG_N(2)) u_b (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .mean_out(mean_b), .sd_out(sd_b), .dbg_state_o(dbg_b));

    sd_window #(.WIDTH(8), .FBITS(0), .LOG_N(0)) u_c (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .mean_out(mean_c), .sd_out(sd_c), .dbg_state_o(dbg_c));

    function automatic int fb_of(input int d);
        return (d == 1) ? 4 : 0;
    endfunction

    function automatic int lg_of(input int d);
        return (d == 2) ? 0 : 2;
    endfunction

    function automatic logic [7:0] get_mean(input int d);
        case (d)
            0:       return mean_a;
            1:       return mean_b;
            default: return mean_c;
        endcase
    endfunction

    function automatic logic [11:0] get_sd(input int d);
        case (d)
            0:       return {4'b0, sd_a};
            1:       return sd_b;
            default: return {4'b0, sd_c};
        endcase
    endfunction

    // Reference: plain integer statistics and a brute-force integer square root.
    function automatic logic [19:0] model(input int d);
        longint n, sum, sq, mean, msq, v, rad, r;
        n = longint'(1) << lg_of(d);
        sum = 0;
        sq = 0;
        foreach (smp_q[i]) begin
            sum += smp_q[i];
            sq  += longint'(smp_q[i]) * smp_q[i];
        end
        mean = sum / n;
        msq  = sq / n;
        v    = msq - mean * mean;
        rad  = v * (longint'(1) << (2 * fb_of(d)));
        r    = 0;
        while ((r + 1) * (r + 1) <= rad) r++;
`ifdef SD_ROUND_EN
        if ((rad - r * r > r) && (r < (longint'(1) << (8 + fb_of(d))) - 1)) r++;
`endif
        return {mean[7:0], r[11:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = '0;
        out_ready = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic send_samples(input int d, input int gap_max, input string tag);
        int guard;
        foreach (smp_q[i]) begin
            repeat ($urandom_range(0, gap_max)) step();
            in_valid[d] = 1'b1;
            in_data[d]  = 8'(smp_q[i]);
            guard = 0;
            while (!in_ready[d] && guard < 64) begin
                step();
                guard++;
            end
            if (guard >= 64) begin
                checks++;
                errors++;
                $display("FAIL %s in_ready_timeout: got 0 expected 1", tag);
            end
            step();
            in_valid[d] = 1'b0;
        end
    endtask

    task automatic run_window(input int d, input int gap_max, input int hold, input string tag);
        logic [19:0] exp;
        logic [7:0]  m0;
        logic [11:0] s0;
        int n;
        bit bad;
        exp_q.push_back(model(d));
        out_ready[d] = (hold == 0);
        send_samples(d, gap_max, tag);
        n = 0;
        while (!out_valid[d] && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n !== 8 + fb_of(d) + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles expected %0d", tag, n + 1, 8 + fb_of(d) + 2);
        end
        exp = exp_q.pop_front();
        checks++;
        if (get_mean(d) !== exp[19:12]) begin
            errors++;
            $display("FAIL %s mean_out: got %0d expected %0d", tag, get_mean(d), exp[19:12]);
        end
        checks++;
        if (get_sd(d) !== exp[11:0]) begin
            errors++;
            $display("FAIL %s sd_out: got %0d expected %0d", tag, get_sd(d), exp[11:0]);
        end
        m0 = get_mean(d);
        s0 = get_sd(d);
        bad = 1'b0;
        for (int k = 0; k < hold; k++) begin
            in_valid[d] = 1'($urandom_range(0, 1));
            in_data[d]  = 8'($urandom_range(0, 255));
            step();
            if (out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0 ||
                get_mean(d) !== m0 || get_sd(d) !== s0) bad = 1'b1;
        end
        if (hold > 0) begin
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s hold_stable: got changed outputs expected stable for %0d cycles", tag, hold);
            end
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        step();
        checks++;
        if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s handshake: got out_valid=%0d in_ready=%0d expected 0 and 1",
                     tag, out_valid[d], in_ready[d]);
        end
        out_ready[d] = 1'b0;
        smp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags[%0d]: got in_ready=%0d out_valid=%0d expected 1 and 0",
                         d, in_ready[d], out_valid[d]);
            end
            checks++;
            if (get_mean(d) !== 8'd0 || get_sd(d) !== 12'd0) begin
                errors++;
                $display("FAIL reset_data[%0d]: got mean=%0d sd=%0d expected 0 and 0",
                         d, get_mean(d), get_sd(d));
            end
        end
        checks++;
        if (dbg_a !== ST_ACCUM) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_a, ST_ACCUM);
        end
    endtask

    task automatic test_basic();
        smp_q = '{2, 4, 4, 6};
        run_window(0, 0, 1, "basic");
        smp_q = '{0, 0, 255, 255};
        run_window(0, 2, 1, "extreme");
    endtask

    task automatic test_fraction();
        smp_q = '{2, 4, 4, 6};
        run_window(1, 1, 1, "frac");
    endtask

    task automatic test_backpressure();
        smp_q = '{200, 200, 200, 200};
        run_window(0, 0, 10, "bp_const");
        repeat (4) smp_q.push_back($urandom_range(0, 255));
        run_window(0, 0, 0, "bp_next");
    endtask

    task automatic test_reset_mid_root();
        bit bad;
        smp_q = '{2, 4, 4, 6};
        send_samples(0, 0, "midroot");
        smp_q.delete();
        step();
        step();
        step();
        checks++;
        if (dbg_a !== ST_ROOT) begin
            errors++;
            $display("FAIL midroot_state: got %0d expected %0d", dbg_a, ST_ROOT);
        end
        do_reset();
        bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) bad = 1'b1;
            step();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL midroot_quiet: got stale out_valid or in_ready low expected idle");
        end
        smp_q = '{2, 4, 4, 6};
        run_window(0, 1, 2, "after_reset");
    endtask

    task automatic test_back_to_back();
        for (int w = 0; w < 8; w++) begin
            smp_q.push_back($urandom_range(0, 255));
            run_window(2, 0, 0, "log0");
        end
    endtask

    task automatic test_random();
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < 4; i++) smp_q.push_back($urandom_range(0, 255));
            run_window(w % 2, 2, $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        in_data[0] = '0;
        in_data[1] = '0;
        in_data[2] = '0;
        test_reset();
        test_basic();
        test_fraction();
        test_backpressure();
        test_reset_mid_root();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
